// File: rtl/wvlt_pkg.sv
// ----------------------------------------------------------------------------
// wvlt_pkg
// Shared types and constants for the wavelet upsampler (wvlt_upsamp) and its
// coefficient-pair FIFO (wvlt_pair_fifo).
//   cWVLT_W      default coefficient width in bits
//   coef_pair_t  packed {a, d} coefficient pair at the default width. The FIFO
//                word in wvlt_upsamp uses the same bit order, with a in the
//                upper half and d in the lower half.
//   ph_t         output phase. EVEN pops a pair. ODD inserts a zero sample.
// ----------------------------------------------------------------------------
package wvlt_pkg;

  localparam int cWVLT_W = 18;

  typedef struct packed {
    logic signed [cWVLT_W-1:0] a;
    logic signed [cWVLT_W-1:0] d;
  } coef_pair_t;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } ph_t;

endpackage

// File: rtl/wvlt_pair_fifo.sv
// ----------------------------------------------------------------------------
// wvlt_pair_fifo
// Single-clock FIFO that stores packed coefficient pairs.
// The read word is the head entry. It is valid whenever oempty is 0. The
// consumer registers the word on the same edge on which it pops.
// A push is never visible to the read side before the following cycle, so the
// FIFO has no fall-through path.
// The pointers are one bit wider than the address. When the pointers differ
// only in the MSB, the FIFO is full. When the pointers are equal, it is empty.
// Ports:
//   iclk    clock
//   irst    asynchronous active-low reset (empties the FIFO)
//   iwr     push request. Ignored when full, unless ird pops in the same cycle.
//   iwdat   word to push
//   ird     pop request. Ignored when empty.
//   ordat   head word
//   ofull   FIFO full
//   oempty  FIFO empty
// Parameters: pW word width, pDEPTH entries (a power of 2, at least 2).
// ----------------------------------------------------------------------------
module wvlt_pair_fifo #(
  parameter int pW     = 36,
  parameter int pDEPTH = 4
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          iwr,
  input  logic [pW-1:0] iwdat,
  input  logic          ird,
  output logic [pW-1:0] ordat,
  output logic          ofull,
  output logic          oempty
);

  localparam int cAW = $clog2(pDEPTH);

  logic [cAW:0]  wr_ptr_reg;
  logic [cAW:0]  rd_ptr_reg;
  logic [pW-1:0] mem [pDEPTH];
  logic          wr_en;
  logic          rd_en;

  // A push is allowed while full only if the head leaves in the same cycle.
  assign rd_en = ird & ~oempty;
  assign wr_en = iwr & (~ofull | rd_en);

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage is not reset. Only the pointers determine which entries are valid.
  always_ff @(posedge iclk) begin
    if (wr_en) mem[wr_ptr_reg[cAW-1:0]] <= iwdat;
  end

  assign ordat  = mem[rd_ptr_reg[cAW-1:0]];
  assign ofull  = (wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {cAW{1'b0}}};
  assign oempty = (wr_ptr_reg == rd_ptr_reg);

endmodule

// File: rtl/wvlt_upsamp.sv
// ----------------------------------------------------------------------------
// wvlt_upsamp
// Upsamples wavelet coefficients by 2 with zero insertion, for an inverse DWT
// stage. Input pairs {a, d} arrive at any time and are buffered. On each
// output strobe the block does one of three things:
//   - Phase EVEN with a pair available: it emits the pair.
//   - Phase ODD: it emits zeros.
//   - Phase EVEN with the FIFO empty: it stalls. If the stream has already
//     started, this stall is an underrun.
// Ports:
//   iclk      clock
//   irst      asynchronous active-low reset
//   iclk_ena  output-sample strobe, one iclk cycle wide
//   ival      qualifies idat_a/idat_d
//   idat_a    approximation coefficient (signed)
//   idat_d    detail coefficient (signed)
//   ofull     FIFO full
//   odat_l    zero-inserted approximation stream (to the low filter)
//   odat_h    zero-inserted detail stream (to the high filter)
//   oena      one-cycle enable for each emitted output sample
//   ounf      sticky underrun flag
//   oovf      sticky overflow flag (a pair was dropped)
// Optional (macro WVLT_UPSAMP_STAT_EN):
//   ounf_cnt  saturating count of underrun events
//   oovf_cnt  saturating count of dropped pairs
// ----------------------------------------------------------------------------
module wvlt_upsamp
  import wvlt_pkg::*;
#(
  parameter int pW     = cWVLT_W,
  parameter int pDEPTH = 4
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 iclk_ena,
  input  logic                 ival,
  input  logic signed [pW-1:0] idat_a,
  input  logic signed [pW-1:0] idat_d,
  output logic                 ofull,
  output logic signed [pW-1:0] odat_l,
  output logic signed [pW-1:0] odat_h,
  output logic                 oena,
  output logic                 ounf,
  output logic                 oovf
`ifdef WVLT_UPSAMP_STAT_EN
  ,
  output logic [15:0]          ounf_cnt,
  output logic [15:0]          oovf_cnt
`endif
);

  ph_t              ph_reg, ph_next;
  logic [pW-1:0]    dat_l_reg, dat_l_next;
  logic [pW-1:0]    dat_h_reg, dat_h_next;
  logic             ena_reg, ena_next;
  logic             unf_reg, unf_next;
  logic             ovf_reg, ovf_next;
  logic             popped_reg, popped_next;

  logic [2*pW-1:0]  fifo_rdat;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             unf_evt;

  // Pop only on an EVEN strobe with data present. The FIFO has no
  // fall-through, so a pair pushed in this same cycle cannot be popped yet.
  assign pop     = iclk_ena & (ph_reg == EVEN) & ~fifo_empty;
  assign push    = ival & (~fifo_full | pop);
  assign drop    = ival & fifo_full & ~pop;
  // A stall before the first pop is the normal start-up condition, not an
  // underrun.
  assign unf_evt = iclk_ena & (ph_reg == EVEN) & fifo_empty & popped_reg;

  wvlt_pair_fifo #(
    .pW     (2 * pW),
    .pDEPTH (pDEPTH)
  ) u_fifo (
    .iclk   (iclk),
    .irst   (irst),
    .iwr    (push),
    .iwdat  ({idat_a, idat_d}),
    .ird    (pop),
    .ordat  (fifo_rdat),
    .ofull  (fifo_full),
    .oempty (fifo_empty)
  );

  always_comb begin
    ph_next     = ph_reg;
    dat_l_next  = dat_l_reg;
    dat_h_next  = dat_h_reg;
    ena_next    = 1'b0;
    popped_next = popped_reg;
    unf_next    = unf_reg | unf_evt;
    ovf_next    = ovf_reg | drop;
    if (iclk_ena) begin
      // The output defaults to zero. Only an EVEN pop loads a coefficient pair.
      dat_l_next = '0;
      dat_h_next = '0;
      unique case (ph_reg)
        EVEN: begin
          if (!fifo_empty) begin
            dat_l_next  = fifo_rdat[2*pW-1:pW];
            dat_h_next  = fifo_rdat[pW-1:0];
            ena_next    = 1'b1;
            ph_next     = ODD;
            popped_next = 1'b1;
          end
        end
        ODD: begin
          ena_next = 1'b1;
          ph_next  = EVEN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      ph_reg     <= EVEN;
      dat_l_reg  <= '0;
      dat_h_reg  <= '0;
      ena_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      popped_reg <= 1'b0;
    end else begin
      ph_reg     <= ph_next;
      dat_l_reg  <= dat_l_next;
      dat_h_reg  <= dat_h_next;
      ena_reg    <= ena_next;
      unf_reg    <= unf_next;
      ovf_reg    <= ovf_next;
      popped_reg <= popped_next;
    end
  end

  assign ofull  = fifo_full;
  assign odat_l = dat_l_reg;
  assign odat_h = dat_h_reg;
  assign oena   = ena_reg;
  assign ounf   = unf_reg;
  assign oovf   = ovf_reg;

`ifdef WVLT_UPSAMP_STAT_EN
  logic [15:0] unf_cnt_reg;
  logic [15:0] ovf_cnt_reg;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      unf_cnt_reg <= '0;
      ovf_cnt_reg <= '0;
    end else begin
      if (unf_evt && (unf_cnt_reg != 16'hFFFF)) unf_cnt_reg <= unf_cnt_reg + 16'd1;
      if (drop    && (ovf_cnt_reg != 16'hFFFF)) ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
    end
  end

  assign ounf_cnt = unf_cnt_reg;
  assign oovf_cnt = ovf_cnt_reg;
`endif

endmodule

// File: tb/tb_wvlt_upsamp.sv
// ----------------------------------------------------------------------------
// tb_wvlt_upsamp
// Self-checking bench for wvlt_upsamp (pW=18, pDEPTH=4).
// A queue-based reference model follows the data-flow rules: it pops before it
// pushes, it alternates phases, and it keeps sticky flags. Directed scenarios
// check fixed expected values. A randomized run compares every cycle against
// the model.
// ----------------------------------------------------------------------------
module tb_wvlt_upsamp;

  localparam int W = 18;
  localparam int D = 4;

  logic         iclk = 1'b0;
  logic         irst = 1'b1;
  logic         iclk_ena = 1'b0;
  logic         ival = 1'b0;
  logic [W-1:0] idat_a = '0;
  logic [W-1:0] idat_d = '0;
  logic         ofull, oena, ounf, oovf;
  logic [W-1:0] odat_l, odat_h;
`ifdef WVLT_UPSAMP_STAT_EN
  logic [15:0]  ounf_cnt, oovf_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [2*W-1:0] m_q[$];
  logic           m_ph, m_popped, m_unf, m_ovf, m_ena;
  logic [W-1:0]   m_l, m_h;

  always #5 iclk = ~iclk;

  wvlt_upsamp #(.pW(W), .pDEPTH(D)) dut (
    .iclk     (iclk),
    .irst     (irst),
    .iclk_ena (iclk_ena),
    .ival     (ival),
    .idat_a   (idat_a),
    .idat_d   (idat_d),
    .ofull    (ofull),
    .odat_l   (odat_l),
    .odat_h   (odat_h),
    .oena     (oena),
    .ounf     (ounf),
    .oovf     (oovf)
`ifdef WVLT_UPSAMP_STAT_EN
    ,
    .ounf_cnt (ounf_cnt),
    .oovf_cnt (oovf_cnt)
`endif
  );

  task automatic model_reset;
    m_q.delete();
    m_ph = 1'b0; m_popped = 1'b0; m_unf = 1'b0; m_ovf = 1'b0; m_ena = 1'b0;
    m_l = '0; m_h = '0;
  endtask

  // Apply one cycle of inputs. Advance the model. Return at the next posedge + 1.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] d, input logic s);
    bit was_empty, was_full, pop;
    ival = v; idat_a = a; idat_d = d; iclk_ena = s;
    was_empty = (m_q.size() == 0);
    was_full  = (m_q.size() == D);
    pop = s && !m_ph && !was_empty;
    m_ena = 1'b0;
    if (s) begin
      m_l = '0; m_h = '0;
      if (m_ph) begin
        m_ena = 1'b1; m_ph = 1'b0;
      end else if (!was_empty) begin
        {m_l, m_h} = m_q.pop_front();
        m_ena = 1'b1; m_ph = 1'b1; m_popped = 1'b1;
      end else if (m_popped) begin
        m_unf = 1'b1;
      end
    end
    if (v) begin
      if (!was_full || pop) m_q.push_back({a, d});
      else m_ovf = 1'b1;
    end
    @(posedge iclk); #1;
    ival = 1'b0; iclk_ena = 1'b0;
  endtask

  task automatic do_reset;
    irst = 1'b0;
    repeat (2) @(posedge iclk);
    #1 irst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset;
    irst = 1'b1;
    #2 irst = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    n_cmp++;
    if ({odat_l, odat_h, oena, ofull, ounf, oovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got l=%h h=%h ena=%b full=%b unf=%b ovf=%b required all 0",
               odat_l, odat_h, oena, ofull, ounf, oovf);
    end
    irst = 1'b1;
    model_reset();
    // A strobe on an empty FIFO before any pop: this is a stall, not an underrun.
    cycle(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({oena, ounf} !== 2'b00) begin
      n_bad++;
      $display("FAIL startup_stall: got ena=%b unf=%b required 0 0", oena, ounf);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    int el[4] = '{100, 0, 7, 0};
    int eh[4] = '{-5, 0, 3, 0};
    int n_ena = 0;
    do_reset();
    cycle(1'b1, W'(100), W'(-5), 1'b0);
    cycle(1'b1, W'(7), W'(3), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 1'b1);
      if (oena === 1'b1) n_ena++;
      n_cmp++;
      if ({oena, odat_l, odat_h} !== {1'b1, W'(el[i]), W'(eh[i])}) begin
        n_bad++;
        $display("FAIL basic_strobe[%0d]: got ena=%b l=%h h=%h required 1 %h %h",
                 i, oena, odat_l, odat_h, W'(el[i]), W'(eh[i]));
      end
      cycle(1'b0, '0, '0, 1'b0);
      n_cmp++;
      if ({oena, odat_l, odat_h} !== {1'b0, W'(el[i]), W'(eh[i])}) begin
        n_bad++;
        $display("FAIL basic_hold[%0d]: got ena=%b l=%h h=%h required 0 %h %h",
                 i, oena, odat_l, odat_h, W'(el[i]), W'(eh[i]));
      end
    end
    n_cmp++;
    if (n_ena != 4) begin
      n_bad++;
      $display("FAIL basic_ena_count: got %0d required 4", n_ena);
    end
    $display("test_basic done");
  endtask

  task automatic test_overflow;
    logic [W-1:0] pa[5], pd[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pa[i] = W'($urandom); pd[i] = W'($urandom);
      cycle(1'b1, pa[i], pd[i], 1'b0);
      if (i >= 3) begin
        n_cmp++;
        if ({ofull, oovf} !== {1'b1, (i == 4)}) begin
          n_bad++;
          $display("FAIL ovf_push[%0d]: got full=%b ovf=%b required 1 %b", i, ofull, oovf, (i == 4));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 1'b1);
      n_cmp++;
      if ({oena, odat_l, odat_h} !== {1'b1, pa[i], pd[i]}) begin
        n_bad++;
        $display("FAIL ovf_drain[%0d]: got ena=%b l=%h h=%h required 1 %h %h",
                 i, oena, odat_l, odat_h, pa[i], pd[i]);
      end
      cycle(1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b0, '0, '0, 1'b0);
    end
    // The dropped 5th pair must not appear. The next EVEN strobe is an underrun.
    cycle(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({oena, ounf, oovf, odat_l, odat_h} !== {3'b011, {2*W{1'b0}}}) begin
      n_bad++;
      $display("FAIL ovf_fifth_dropped: got ena=%b unf=%b ovf=%b l=%h h=%h required 0 1 1 0 0",
               oena, ounf, oovf, odat_l, odat_h);
    end
    $display("test_overflow done");
  endtask

  task automatic test_underrun;
    logic [W-1:0] a0, d0, a1, d1;
    a0 = W'($urandom); d0 = W'($urandom); a1 = W'($urandom); d1 = W'($urandom);
    do_reset();
    cycle(1'b1, a0, d0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({oena, odat_l, odat_h} !== {1'b1, a0, d0}) begin
      n_bad++;
      $display("FAIL unf_first: got ena=%b l=%h h=%h required 1 %h %h", oena, odat_l, odat_h, a0, d0);
    end
    cycle(1'b0, '0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({oena, ounf, odat_l, odat_h} !== {2'b10, {2*W{1'b0}}}) begin
      n_bad++;
      $display("FAIL unf_odd: got ena=%b unf=%b l=%h h=%h required 1 0 0 0", oena, ounf, odat_l, odat_h);
    end
    cycle(1'b0, '0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({oena, ounf, odat_l, odat_h} !== {2'b01, {2*W{1'b0}}}) begin
      n_bad++;
      $display("FAIL unf_third: got ena=%b unf=%b l=%h h=%h required 0 1 0 0", oena, ounf, odat_l, odat_h);
    end
    cycle(1'b1, a1, d1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({oena, ounf, odat_l, odat_h} !== {2'b11, a1, d1}) begin
      n_bad++;
      $display("FAIL unf_resume: got ena=%b unf=%b l=%h h=%h required 1 1 %h %h",
               oena, ounf, odat_l, odat_h, a1, d1);
    end
    $display("test_underrun done");
  endtask

  task automatic test_full_push_pop;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   a, d;
    do_reset();
    for (int i = 0; i < D; i++) begin
      a = W'($urandom); d = W'($urandom);
      exp_q.push_back({a, d});
      cycle(1'b1, a, d, 1'b0);
    end
    n_cmp++;
    if (ofull !== 1'b1) begin
      n_bad++;
      $display("FAIL fpp_full: got %b required 1", ofull);
    end
    a = W'($urandom); d = W'($urandom);
    exp_q.push_back({a, d});
    cycle(1'b1, a, d, 1'b1);
    n_cmp++;
    if ({ofull, oovf, oena, odat_l, odat_h} !== {3'b101, exp_q[0]}) begin
      n_bad++;
      $display("FAIL fpp_same_cycle: got full=%b ovf=%b ena=%b l=%h h=%h required 1 0 1 %h",
               ofull, oovf, oena, odat_l, odat_h, exp_q[0]);
    end
    void'(exp_q.pop_front());
    for (int i = 0; i < D; i++) begin
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      n_cmp++;
      if ({oena, oovf, odat_l, odat_h} !== {2'b10, exp_q[i]}) begin
        n_bad++;
        $display("FAIL fpp_drain[%0d]: got ena=%b ovf=%b data=%h required 1 0 %h",
                 i, oena, oovf, {odat_l, odat_h}, exp_q[i]);
      end
      cycle(1'b0, '0, '0, 1'b0);
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_reset_midstream;
    do_reset();
    cycle(1'b1, W'(11), W'(-22), 1'b0);
    cycle(1'b1, W'(33), W'(44), 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    irst = 1'b0;
    #1;
    n_cmp++;
    if ({odat_l, odat_h, oena, ofull, ounf, oovf} !== '0) begin
      n_bad++;
      $display("FAIL midrst_async: got l=%h h=%h ena=%b full=%b unf=%b ovf=%b required all 0",
               odat_l, odat_h, oena, ofull, ounf, oovf);
    end
    @(posedge iclk); #1;
    irst = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, '0, '0, 1'b1);
      n_cmp++;
      if ({oena, ounf} !== 2'b00) begin
        n_bad++;
        $display("FAIL midrst_empty[%0d]: got ena=%b unf=%b required 0 0", i, oena, ounf);
      end
      cycle(1'b0, '0, '0, 1'b0);
    end
    cycle(1'b1, W'(55), W'(66), 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({oena, odat_l, odat_h} !== {1'b1, W'(55), W'(66)}) begin
      n_bad++;
      $display("FAIL midrst_restart: got ena=%b l=%h h=%h required 1 %h %h",
               oena, odat_l, odat_h, W'(55), W'(66));
    end
    cycle(1'b0, '0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({oena, odat_l, odat_h} !== {1'b1, {2*W{1'b0}}}) begin
      n_bad++;
      $display("FAIL midrst_odd: got ena=%b l=%h h=%h required 1 0 0", oena, odat_l, odat_h);
    end
    $display("test_reset_midstream done");
  endtask

  task automatic test_random;
    logic [2*W+3:0] got, exp;
    logic           v, s;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      // The first half is push-heavy to reach overflow. The second half is
      // strobe-heavy to reach underrun.
      if (k < 400) begin
        v = ($urandom_range(0, 3) != 0); s = ($urandom_range(0, 7) == 0);
      end else begin
        v = ($urandom_range(0, 7) == 0); s = ($urandom_range(0, 1) == 0);
      end
      cycle(v, W'($urandom), W'($urandom), s);
      got = {ofull, oena, ounf, oovf, odat_l, odat_h};
      exp = {(m_q.size() == D), m_ena, m_unf, m_ovf, m_l, m_h};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random[%0d]: got full/ena/unf/ovf/l/h=%h required %h", k, got, exp);
      end
    end
    $display("test_random done");
  endtask

`ifdef WVLT_UPSAMP_STAT_EN
  task automatic test_stat;
    do_reset();
    for (int i = 0; i < D + 3; i++) cycle(1'b1, W'(i), W'(i), 1'b0);
    n_cmp++;
    if ({ounf_cnt, oovf_cnt} !== {16'd0, 16'd3}) begin
      n_bad++;
      $display("FAIL stat_small: got unf_cnt=%h ovf_cnt=%h required 0000 0003", ounf_cnt, oovf_cnt);
    end
    ival = 1'b1;
    repeat (70000) @(posedge iclk);
    #1 ival = 1'b0;
    n_cmp++;
    if (oovf_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL stat_saturate: got ovf_cnt=%h required ffff", oovf_cnt);
    end
    do_reset();
    n_cmp++;
    if ({ounf_cnt, oovf_cnt} !== 32'd0) begin
      n_bad++;
      $display("FAIL stat_reset: got unf_cnt=%h ovf_cnt=%h required 0 0", ounf_cnt, oovf_cnt);
    end
    $display("test_stat done");
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_underrun();
    test_full_push_pop();
    test_reset_midstream();
    test_random();
`ifdef WVLT_UPSAMP_STAT_EN
    test_stat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
